aes_decrypt_scheduler: RTL and testbench

AES_DECRYPT_SCHEDULER -- requirements
Module: aes_decrypt_scheduler

---
 rtl/aes_decrypt_scheduler.sv | 132 +++++++++++++
 tb/tb_aes_decrypt_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_scheduler.sv
// aes_decrypt_scheduler
//   Collects 16 received ciphertext bytes into a 128-bit block, launches the
//   decrypt core, waits for its result and streams the plaintext back out
//   byte by byte over a valid/ready transmitter handshake.
//
//   Optional feature: define AES_SCHED_TIMEOUT_EN to abort a WAIT that lasts
//   TIMEOUT_CYCLES cycles without core_done (sets sticky err_timeout). Without
//   the macro WAIT waits forever and err_timeout is tied to 0.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rx_valid/rx_byte  incoming ciphertext byte strobe
//   core_start        one-cycle launch pulse for the decrypt core
//   core_data         assembled ciphertext block (first byte in [127:120])
//   core_done/result  decrypt core completion strobe and plaintext
//   tx_ready/valid/byte  plaintext byte output handshake
//   busy              high in every state except COLLECT
//   overrun           sticky: a byte arrived while not collecting
//   err_timeout       sticky: core did not finish in time
//   block_count       fully transmitted blocks (wraps)
module aes_decrypt_scheduler #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  output logic         core_start,
  output logic [127:0] core_data,
  input  logic         core_done,
  input  logic [127:0] core_result,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_byte,
  output logic         busy,
  output logic         overrun,
  output logic         err_timeout,
  output logic [15:0]  block_count
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_SEND    = 2'd3;

  logic [1:0]   state;
  logic [3:0]   byte_idx;
  logic [3:0]   tx_idx;
  logic [127:0] result_q;
  logic         expire;

  // Status outputs decode straight from state so a reset is visible at once.
  assign core_start = (state == S_START);
  assign tx_valid   = (state == S_SEND);
  assign busy       = (state != S_COLLECT);
  // The result register shifts left on each transfer; the head byte is out.
  assign tx_byte    = result_q[127:120];

`ifdef AES_SCHED_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        err_q;

  // to_cnt is 0 in the first WAIT cycle, so the TIMEOUT_CYCLES-th WAIT
  // cycle is the last one; core_done in that cycle still wins.
  assign expire      = (state == S_WAIT) && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_START)     to_cnt <= '0;
      else if (state == S_WAIT) to_cnt <= to_cnt + 32'd1;
      if (expire && !core_done) err_q <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_COLLECT;
      byte_idx    <= '0;
      tx_idx      <= '0;
      core_data   <= '0;
      result_q    <= '0;
      overrun     <= 1'b0;
      block_count <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (rx_valid) begin
            core_data <= {core_data[119:0], rx_byte};
            byte_idx  <= byte_idx + 4'd1;   // wraps to 0 after the 16th byte
            if (byte_idx == 4'd15) state <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            result_q <= core_result;
            tx_idx   <= '0;
            state    <= S_SEND;
          end else if (expire) begin
            byte_idx <= '0;
            state    <= S_COLLECT;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            result_q <= {result_q[119:0], 8'h00};
            tx_idx   <= tx_idx + 4'd1;
            if (tx_idx == 4'd15) begin
              block_count <= block_count + 16'd1;
              byte_idx    <= '0;
              state       <= S_COLLECT;
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
      // Bytes outside COLLECT are dropped; byte_idx is left alone.
      if (rx_valid && state != S_COLLECT) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
module tb_aes_decrypt_scheduler;
  logic         clk = 0;
  logic         rst = 1;
  logic         rx_valid = 0;
  logic [7:0]   rx_byte = 0;
  logic         core_start;
  logic [127:0] core_data;
  logic         core_done = 0;
  logic [127:0] core_result = 0;
  logic         tx_ready = 0;
  logic         tx_valid;
  logic [7:0]   tx_byte;
  logic         busy;
  logic         overrun;
  logic         err_timeout;
  logic [15:0]  block_count;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  aes_decrypt_scheduler #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .core_start(core_start), .core_data(core_data), .core_done(core_done),
    .core_result(core_result), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_byte(tx_byte), .busy(busy), .overrun(overrun),
    .err_timeout(err_timeout), .block_count(block_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_start) start_cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] seq_block(input logic [7:0] base);
    logic [127:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], base + 8'(i)};
    return b;
  endfunction

  // Leaves the DUT in START (cycle after the 16th byte).
  task automatic send_block(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1; rx_byte = base + 8'(i);
      tick();
    end
    rx_valid = 0;
  endtask

  // From START: core_done arrives dly cycles after the start cycle.
  task automatic core_reply(input int dly, input logic [127:0] res);
    repeat (dly) tick();
    core_done = 1; core_result = res;
    tick();
    core_done = 0; core_result = '0;
  endtask

  // pat 0: always ready; pat 1: ready pattern 1,0,0,1 repeating.
  task automatic recv(input int pat, input int nbytes, input logic [127:0] res);
    int got = 0;
    int cyc = 0;
    logic [7:0] prev = 0;
    logic stalled = 0;
    while (got < nbytes && cyc < 200) begin
      tx_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (stalled) begin
        chk("hold_valid", tx_valid, 1'b1);
        chk("hold_byte", tx_byte, prev);
      end
      if (tx_valid && tx_ready) begin
        chk($sformatf("tx_byte%0d", got), tx_byte, res[127-8*got -: 8]);
        got++;
        stalled = 0;
      end else begin
        stalled = tx_valid;
        prev = tx_byte;
      end
      tick();
      cyc++;
    end
    chk("tx_count", got, nbytes);
    tx_ready = 0;
  endtask

  logic [127:0] r1, r2, r3, r4;

  initial begin
    r1 = seq_block(8'hF0);
    r2 = seq_block(8'hA0);
    r3 = seq_block(8'h50);
    r4 = seq_block(8'hC3);
    repeat (2) tick();
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txb", tx_byte, 0);
    chk("rst_start", core_start, 0);
    chk("rst_data", core_data, 0);
    chk("rst_cnt", block_count, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_err", err_timeout, 0);
    rst = 0;
    tick();
    // stray core_done in COLLECT is ignored
    core_done = 1; core_result = r2;
    tick();
    core_done = 0;
    chk("idle_done_txv", tx_valid, 0);
    chk("idle_done_busy", busy, 0);

    // basic block
    send_block(8'h00);
    chk("start_pulse", core_start, 1);
    chk("core_data1", core_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("busy_start", busy, 1);
    tick();
    chk("start_gone", core_start, 0);
    chk("wait_txv", tx_valid, 0);
    repeat (8) tick();
    core_done = 1; core_result = r1;
    tick();
    core_done = 0;
    chk("send_txv", tx_valid, 1);
    chk("send_first", tx_byte, 8'hF0);
    chk("data_held", core_data, 128'h000102030405060708090A0B0C0D0E0F);
    recv(0, 16, r1);
    chk("cnt1", block_count, 1);
    chk("busy_idle1", busy, 0);
    chk("txv_idle1", tx_valid, 0);
    chk("start_once", start_cnt, 1);

    // stalled transmitter
    send_block(8'h10);
    chk("core_data2", core_data, seq_block(8'h10));
    core_reply(4, r2);
    recv(1, 16, r2);
    chk("cnt2", block_count, 2);
    chk("txv_idle2", tx_valid, 0);

    // overrun during WAIT
    chk("ovr_pre", overrun, 0);
    send_block(8'h30);
    tick();
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1; rx_byte = 8'hEE; tick();
    end
    rx_valid = 0;
    chk("ovr_set", overrun, 1);
    chk("ovr_data", core_data, seq_block(8'h30));
    core_done = 1; core_result = r3; tick(); core_done = 0;
    recv(0, 16, r3);
    chk("cnt3", block_count, 3);
    send_block(8'h20);
    chk("ovr_next_data", core_data, seq_block(8'h20));
    chk("ovr_next_start", core_start, 1);
    core_reply(3, r4);
    recv(0, 16, r4);
    chk("cnt4", block_count, 4);
    chk("ovr_sticky", overrun, 1);

    // reset mid-SEND after byte 5
    send_block(8'h40);
    core_reply(2, r1);
    recv(0, 5, r1);
    rst = 1; #1;
    chk("mrst_txv", tx_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_txb", tx_byte, 0);
    chk("mrst_cnt", block_count, 0);
    chk("mrst_ovr", overrun, 0);
    chk("mrst_data", core_data, 0);
    tick();
    rst = 0;
    tick();
    send_block(8'h60);
    chk("post_rst_data", core_data, seq_block(8'h60));
    core_reply(10, r2);
    recv(0, 16, r2);
    chk("post_rst_cnt", block_count, 1);

`ifdef AES_SCHED_TIMEOUT_EN
    begin
      int txv_seen = 0;
      send_block(8'h70);
      tick();                       // WAIT cycle 1
      for (int k = 1; k < 50; k++) begin
        if (tx_valid) txv_seen++;
        tick();
      end
      chk("to_pre_err", err_timeout, 0);  // in WAIT cycle 50
      chk("to_pre_busy", busy, 1);
      tick();
      chk("to_err", err_timeout, 1);
      chk("to_busy", busy, 0);
      chk("to_txv", txv_seen + int'(tx_valid), 0);
      chk("to_cnt", block_count, 1);
      send_block(8'h80);
      chk("to_data", core_data, seq_block(8'h80));
      tick();
      repeat (49) tick();
      core_done = 1; core_result = r3; tick(); core_done = 0;
      chk("to_win_txv", tx_valid, 1);
      recv(0, 16, r3);
      chk("to_win_cnt", block_count, 2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
